chimera_cluster_pwr_seq: RTL and testbench
==========================================

Name: chimera_cluster_pwr_seq

Overview:
- Parametrised per-cluster power sequencer in the Chimera top-level, driven by the top-level config registers.
- Each of NumClusters channels runs an independent FSM that orders clock enable, reset release, isolation release and the reverse power-down.
- Isolation handshakes with the per-cluster AXI isolate unit, bounded by a timeout.
- With IsolateClusters=0, the isolation steps are skipped.

Parameters:
- NumClusters, 5, number of independent cluster channels.
- IsolateClusters, 1, 1 = isolation handshake active; 0 = isolate_o tied 0 and ISO states bypassed.
- ResetCycles, 8, cycles reset is held with clock running before release (>=1).
- SettleCycles, 4, cycles after reset release before isolation release (>=1).
- TimeoutCycles, 1024, maximum wait for isolated_i handshake (>=1).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- en_req_i  in  NumClusters  per-cluster power request (level; 1 = on).
- isolated_i  in  NumClusters  isolation status from the AXI isolate unit (1 = isolated, no outstanding transactions).
- timeout_clr_i  in  NumClusters  single-cycle clear of the sticky timeout flag.
- clk_en_o  out  NumClusters  cluster clock-gate enable.
- cluster_rst_no  out  NumClusters  cluster reset, active-low.
- isolate_o  out  NumClusters  isolation request.
- on_o  out  NumClusters  1 only in state ON.
- busy_o  out  NumClusters  1 in any state other than OFF or ON.
- timeout_o  out  NumClusters  sticky isolation-handshake timeout flag.

Behaviour:
- Reset (async assert, sync release), all channels: state OFF; clk_en_o=0; cluster_rst_no=0; isolate_o=IsolateClusters; on_o=0; busy_o=0; timeout_o=0; counters=0.
- All outputs are registered; outputs change in the cycle after the state transition.
- Counter width is $clog2(max(ResetCycles,SettleCycles,TimeoutCycles)+1). The counter clears on every state entry.
- Power-up FSM:
  - OFF: all outputs at reset values; en_req_i=1 -> CLK_ON.
  - CLK_ON: clk_en_o=1, reset still asserted; after ResetCycles cycles -> RST_REL.
  - RST_REL: cluster_rst_no=1; after SettleCycles cycles -> ISO_REL, or -> ON if IsolateClusters=0.
  - ISO_REL: isolate_o=0; wait for isolated_i=0, then -> ON.
  - ON: on_o=1; en_req_i=0 -> ISO_REQ, or -> RST_ON if IsolateClusters=0.
- Power-down FSM:
  - ISO_REQ: isolate_o=1; wait for isolated_i=1, then -> RST_ON.
  - RST_ON: cluster_rst_no=0, clock still running; hold ResetCycles cycles -> CLK_OFF.
  - CLK_OFF: clk_en_o=0; one cycle -> OFF.
- Timeout: in ISO_REL or ISO_REQ, if the awaited isolated_i level is not seen within TimeoutCycles cycles:
  - set timeout_o;
  - proceed to the next state anyway (ON or RST_ON), forcing progress.
- Request changes mid-sequence are ignored. The sequence always completes to ON or OFF; en_req_i is re-sampled only in OFF or ON. A pulse shorter than the sequence length therefore gives a full up-then-down cycle if en_req_i is low on arrival at ON.
- timeout_o: timeout_clr_i and a new timeout in the same cycle -> flag stays 1 (set wins).
- Channels are fully independent; simultaneous requests on all channels proceed in parallel.
- Reset asserted mid-sequence -> immediate return to reset values. The cluster is isolated, reset and clock-gated in the same instant; this is acceptable because clk_en_o is gated off.
- busy_o is 1 in CLK_ON, RST_REL, ISO_REL, ISO_REQ, RST_ON and CLK_OFF.
- Power-up latency with isolated_i dropping immediately (cycles from en_req_i rise to on_o=1): 1 + ResetCycles + SettleCycles + 1 + 1.
  - Defaults: 15 cycles.
  - IsolateClusters=0: 1 + ResetCycles + SettleCycles + 1.

Test Plan:
- Defaults; raise en_req_i[2], isolated_i[2] follows isolate_o[2] after 1 cycle -> clk_en_o[2] rises at cycle 2, cluster_rst_no[2] at cycle 10, isolate_o[2] falls at cycle 14, on_o[2]=1 at cycle 16; other channels unchanged.
- From ON, drop en_req_i[0], hold isolated_i[0]=0 -> isolate_o[0]=1, timeout_o[0]=1 after 1024 cycles, then cluster_rst_no[0]=0, after 8 more cycles clk_en_o[0]=0, OFF; timeout_clr_i[0] pulse -> timeout_o[0]=0.
- Pulse en_req_i[1] for 3 cycles -> full power-up to on_o[1]=1, then immediate power-down back to OFF; busy_o[1] high throughout except the single ON cycle.
- All 5 channels requested in the same cycle -> all on_o bits rise in the same cycle; all busy_o bits fall together.
- IsolateClusters=0, en_req_i[4]=1 -> isolate_o[4] constant 0, on_o[4]=1 at cycle 14; isolated_i ignored, no timeout ever.
- Assert rst_i while channel 3 is in RST_REL -> same-cycle (async) clk_en_o[3]=0, cluster_rst_no[3]=0, isolate_o[3]=1; after release with en_req_i[3] still 1, the sequence restarts from OFF.

Source files
------------

// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: each channel orders clock enable, reset release and
// isolation release on power-up, and the reverse on power-down.
module chimera_cluster_pwr_seq #(
    parameter int unsigned NumClusters     = 5,
    parameter bit          IsolateClusters = 1'b1,
    parameter int unsigned ResetCycles     = 8,
    parameter int unsigned SettleCycles    = 4,
    parameter int unsigned TimeoutCycles   = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] en_req_i,
    input  logic [NumClusters-1:0] isolated_i,
    input  logic [NumClusters-1:0] timeout_clr_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] on_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] timeout_o
);

    localparam int unsigned MaxRs     = (ResetCycles > SettleCycles) ? ResetCycles : SettleCycles;
    localparam int unsigned MaxCycles = (MaxRs > TimeoutCycles) ? MaxRs : TimeoutCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] RstLast = CntW'(ResetCycles - 1);
    localparam logic [CntW-1:0] SetLast = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] ToLast  = CntW'(TimeoutCycles - 1);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_CLK_ON  = 3'd1;
    localparam logic [2:0] S_RST_REL = 3'd2;
    localparam logic [2:0] S_ISO_REL = 3'd3;
    localparam logic [2:0] S_ON      = 3'd4;
    localparam logic [2:0] S_ISO_REQ = 3'd5;
    localparam logic [2:0] S_RST_ON  = 3'd6;
    localparam logic [2:0] S_CLK_OFF = 3'd7;

    for (genvar g = 0; g < NumClusters; g++) begin : g_ch
        logic [2:0]      state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            cnt_run, to_set;
        logic            clk_en_q, clk_en_d;
        logic            rst_n_q, rst_n_d;
        logic            iso_q, iso_d;
        logic            on_q, on_d;
        logic            busy_q, busy_d;
        logic            timeout_q, timeout_d;

        always_comb begin
            state_d = state_q;
            cnt_run = 1'b0;
            to_set  = 1'b0;
            case (state_q)
                S_OFF:     if (en_req_i[g]) state_d = S_CLK_ON;
                S_CLK_ON: begin
                    cnt_run = 1'b1;
                    if (cnt_q == RstLast) state_d = S_RST_REL;
                end
                S_RST_REL: begin
                    cnt_run = 1'b1;
                    if (cnt_q == SetLast) state_d = IsolateClusters ? S_ISO_REL : S_ON;
                end
                // Handshake seen on the last allowed cycle still counts as success
                S_ISO_REL: begin
                    cnt_run = 1'b1;
                    if (!isolated_i[g]) begin
                        state_d = S_ON;
                    end else if (cnt_q == ToLast) begin
                        state_d = S_ON;
                        to_set  = 1'b1;
                    end
                end
                S_ON:      if (!en_req_i[g]) state_d = IsolateClusters ? S_ISO_REQ : S_RST_ON;
                S_ISO_REQ: begin
                    cnt_run = 1'b1;
                    if (isolated_i[g]) begin
                        state_d = S_RST_ON;
                    end else if (cnt_q == ToLast) begin
                        state_d = S_RST_ON;
                        to_set  = 1'b1;
                    end
                end
                S_RST_ON: begin
                    cnt_run = 1'b1;
                    if (cnt_q == RstLast) state_d = S_CLK_OFF;
                end
                S_CLK_OFF: state_d = S_OFF;
                default:   state_d = S_OFF;
            endcase
            cnt_d = (cnt_run && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
        end

        // Output registers decode the current state, so they lag each transition by one cycle
        always_comb begin
            clk_en_d  = (state_q != S_OFF) && (state_q != S_CLK_OFF);
            rst_n_d   = (state_q == S_RST_REL) || (state_q == S_ISO_REL) ||
                        (state_q == S_ON)      || (state_q == S_ISO_REQ);
            iso_d     = IsolateClusters && (state_q != S_ISO_REL) && (state_q != S_ON);
            on_d      = (state_q == S_ON);
            busy_d    = (state_q != S_OFF) && (state_q != S_ON);
            timeout_d = to_set | (timeout_q & ~timeout_clr_i[g]);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q   <= S_OFF;
                cnt_q     <= '0;
                clk_en_q  <= 1'b0;
                rst_n_q   <= 1'b0;
                iso_q     <= IsolateClusters;
                on_q      <= 1'b0;
                busy_q    <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                clk_en_q  <= clk_en_d;
                rst_n_q   <= rst_n_d;
                iso_q     <= iso_d;
                on_q      <= on_d;
                busy_q    <= busy_d;
                timeout_q <= timeout_d;
            end
        end

        assign clk_en_o[g]       = clk_en_q;
        assign cluster_rst_no[g] = rst_n_q;
        assign isolate_o[g]      = iso_q;
        assign on_o[g]           = on_q;
        assign busy_o[g]         = busy_q;
        assign timeout_o[g]      = timeout_q;
    end

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Self-checking bench for chimera_cluster_pwr_seq: directed table/sequences plus
// randomized traffic against a phase-list reference model, for both isolation modes.
module tb_chimera_cluster_pwr_seq;

    localparam int NC = 5;
    localparam int RC = 8;
    localparam int SC = 4;
    localparam int TC = 1024;

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0] enA, isinA, clrA, clkA, rstnA, isoA, onA, busyA, toA;
    logic [NC-1:0] enB, isinB, clrB, clkB, rstnB, isoB, onB, busyB, toB;
    logic [NC-1:0] fmA;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chimera_cluster_pwr_seq #(
        .NumClusters(NC), .IsolateClusters(1'b1), .ResetCycles(RC),
        .SettleCycles(SC), .TimeoutCycles(TC)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .en_req_i(enA), .isolated_i(isinA),
        .timeout_clr_i(clrA), .clk_en_o(clkA), .cluster_rst_no(rstnA),
        .isolate_o(isoA), .on_o(onA), .busy_o(busyA), .timeout_o(toA)
    );

    chimera_cluster_pwr_seq #(
        .NumClusters(NC), .IsolateClusters(1'b0), .ResetCycles(RC),
        .SettleCycles(SC), .TimeoutCycles(TC)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .en_req_i(enB), .isolated_i(isinB),
        .timeout_clr_i(clrB), .clk_en_o(clkB), .cluster_rst_no(rstnB),
        .isolate_o(isoB), .on_o(onB), .busy_o(busyB), .timeout_o(toB)
    );

    // Reference model: phase index into the sequence
    // OFF, CLK_ON, RST_REL, ISO_REL, ON, ISO_REQ, RST_ON, CLK_OFF (0..7)
    int ph[2][NC];
    int tt[2][NC];
    logic [NC-1:0] e_clk[2], e_rstn[2], e_iso[2], e_on[2], e_busy[2], e_to[2];

    function automatic logic [4:0] decode(input int p, input bit iso);
        logic [4:0] o;
        o[4] = (p >= 1) && (p <= 6);
        o[3] = (p >= 2) && (p <= 5);
        o[2] = iso && !((p == 3) || (p == 4));
        o[1] = (p == 4);
        o[0] = (p != 0) && (p != 4);
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                logic [4:0] o;
                ph[d][c] = 0;
                tt[d][c] = 0;
                o = decode(0, d == 0);
                e_clk[d][c] = o[4]; e_rstn[d][c] = o[3]; e_iso[d][c] = o[2];
                e_on[d][c] = o[1]; e_busy[d][c] = o[0]; e_to[d][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int d, input logic [NC-1:0] en,
                              input logic [NC-1:0] isol, input logic [NC-1:0] clr);
        bit iso;
        iso = (d == 0);
        for (int c = 0; c < NC; c++) begin
            logic [4:0] o;
            int p, nx;
            bit set;
            p = ph[d][c];
            o = decode(p, iso);
            e_clk[d][c] = o[4]; e_rstn[d][c] = o[3]; e_iso[d][c] = o[2];
            e_on[d][c] = o[1]; e_busy[d][c] = o[0];
            nx  = p;
            set = 1'b0;
            case (p)
                0: if (en[c]) nx = 1;
                1: begin tt[d][c]++; if (tt[d][c] == RC) nx = 2; end
                2: begin tt[d][c]++; if (tt[d][c] == SC) nx = iso ? 3 : 4; end
                3: begin
                    tt[d][c]++;
                    if (!isol[c]) nx = 4;
                    else if (tt[d][c] == TC) begin nx = 4; set = 1'b1; end
                end
                4: if (!en[c]) nx = iso ? 5 : 6;
                5: begin
                    tt[d][c]++;
                    if (isol[c]) nx = 6;
                    else if (tt[d][c] == TC) begin nx = 6; set = 1'b1; end
                end
                6: begin tt[d][c]++; if (tt[d][c] == RC) nx = 7; end
                default: nx = 0;
            endcase
            if (nx != p) tt[d][c] = 0;
            ph[d][c] = nx;
            e_to[d][c] = set | (e_to[d][c] & ~clr[c]);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model_A", 32'({clkA, rstnA, isoA, onA, busyA, toA}),
              32'({e_clk[0], e_rstn[0], e_iso[0], e_on[0], e_busy[0], e_to[0]}));
        check("model_B", 32'({clkB, rstnB, isoB, onB, busyB, toB}),
              32'({e_clk[1], e_rstn[1], e_iso[1], e_on[1], e_busy[1], e_to[1]}));
    endtask

    // One clock: inputs present at the edge feed the model, outputs sampled 1ns later
    task automatic step();
        logic [NC-1:0] eA, iA, cA, eB, iB, cB;
        eA = enA; iA = isinA; cA = clrA;
        eB = enB; iB = isinB; cB = clrB;
        @(posedge clk);
        #1;
        model_step(0, eA, iA, cA);
        model_step(1, eB, iB, cB);
        check_model();
        isinA = (isinA & ~fmA) | (isoA & fmA);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        int            cyc;
        logic [NC-1:0] en;
        logic [NC-1:0] clk_en;
        logic [NC-1:0] rstn;
        logic [NC-1:0] iso;
        logic [NC-1:0] on;
        logic [NC-1:0] busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cur, n, m, busy_cnt, on_cnt, first_on;

        tbl[0] = '{1,  5'h04, 5'h00, 5'h00, 5'h1f, 5'h00, 5'h00};
        tbl[1] = '{2,  5'h04, 5'h04, 5'h00, 5'h1f, 5'h00, 5'h04};
        tbl[2] = '{9,  5'h04, 5'h04, 5'h00, 5'h1f, 5'h00, 5'h04};
        tbl[3] = '{10, 5'h04, 5'h04, 5'h04, 5'h1f, 5'h00, 5'h04};
        tbl[4] = '{13, 5'h04, 5'h04, 5'h04, 5'h1f, 5'h00, 5'h04};
        tbl[5] = '{14, 5'h04, 5'h04, 5'h04, 5'h1b, 5'h00, 5'h04};
        tbl[6] = '{15, 5'h04, 5'h04, 5'h04, 5'h1b, 5'h00, 5'h04};
        tbl[7] = '{16, 5'h04, 5'h04, 5'h04, 5'h1b, 5'h04, 5'h00};

        rst = 1'b1;
        enA = '0; clrA = '0; isinA = '1; fmA = '1;
        enB = '0; clrB = '0; isinB = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_en", 32'(clkA), 32'h0);
        check("rst_rst_n", 32'(rstnA), 32'h0);
        check("rst_isolate", 32'(isoA), 32'h1f);
        check("rst_on_busy_to", 32'({onA, busyA, toA}), 32'h0);
        check("rst_isolate_B", 32'(isoB), 32'h0);
        #1 rst = 1'b0;

        // Power-up of channel 2 with isolated_i following isolate_o after one cycle
        cur = 0;
        for (int i = 0; i < 8; i++) begin
            while (cur < tbl[i].cyc) begin
                enA = tbl[i].en;
                step();
                cur++;
            end
            check($sformatf("tbl%0d_clk_en", i), 32'(clkA), 32'(tbl[i].clk_en));
            check($sformatf("tbl%0d_rst_n", i), 32'(rstnA), 32'(tbl[i].rstn));
            check($sformatf("tbl%0d_isolate", i), 32'(isoA), 32'(tbl[i].iso));
            check($sformatf("tbl%0d_on", i), 32'(onA), 32'(tbl[i].on));
            check($sformatf("tbl%0d_busy", i), 32'(busyA), 32'(tbl[i].busy));
        end

        // Channel 0 up, then down with isolated_i stuck low -> ISO_REQ timeout
        enA[0] = 1'b1;
        steps(16);
        check("ch0_on", 32'(onA[0]), 32'h1);
        fmA[0] = 1'b0;
        isinA[0] = 1'b0;
        enA[0] = 1'b0;
        n = 0;
        for (int i = 1; i <= TC + 20; i++) begin
            step();
            if (toA[0] && n == 0) n = i;
            if (n != 0) break;
        end
        check("req_timeout_latency", 32'(n), 32'(TC + 1));
        check("req_timeout_rst_still_high", 32'(rstnA[0]), 32'h1);
        step();
        check("req_timeout_rst_low", 32'(rstnA[0]), 32'h0);
        steps(7);
        check("req_clk_held", 32'(clkA[0]), 32'h1);
        step();
        check("req_clk_off", 32'(clkA[0]), 32'h0);
        step();
        check("req_off_busy", 32'(busyA[0]), 32'h0);
        check("timeout_sticky", 32'(toA[0]), 32'h1);
        clrA[0] = 1'b1;
        step();
        clrA[0] = 1'b0;
        check("timeout_cleared", 32'(toA[0]), 32'h0);

        // ISO_REL timeout with a clear pulse on the very same edge: set wins
        isinA[0] = 1'b1;
        enA[0] = 1'b1;
        m = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!isoA[0] && m == 0) m = i;
            if (m != 0) break;
        end
        check("isorel_fall_cycle", 32'(m), 32'd14);
        steps(TC - 2);
        check("isorel_no_timeout_yet", 32'(toA[0]), 32'h0);
        clrA[0] = 1'b1;
        step();
        clrA[0] = 1'b0;
        check("set_wins_over_clr", 32'(toA[0]), 32'h1);
        step();
        check("isorel_forced_on", 32'(onA[0]), 32'h1);
        clrA[0] = 1'b1;
        step();
        clrA[0] = 1'b0;
        fmA[0] = 1'b1;

        enA = '0;
        steps(40);
        check("all_off_busy", 32'(busyA), 32'h0);
        check("all_off_clk", 32'(clkA), 32'h0);

        // Short request pulse on channel 1: full up then immediate down
        busy_cnt = 0;
        on_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            enA[1] = (i < 3);
            step();
            if (busyA[1]) busy_cnt++;
            if (onA[1]) on_cnt++;
        end
        check("pulse_busy_cycles", 32'(busy_cnt), 32'd25);
        check("pulse_on_cycles", 32'(on_cnt), 32'd1);

        // All channels together
        enA = '1;
        first_on = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("all_on_together", 32'((onA == '0) || (onA == '1)), 32'h1);
            if (onA == '1 && first_on == 0) first_on = i;
        end
        check("all_on_cycle", 32'(first_on), 32'd16);
        enA = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            check("all_busy_together", 32'((busyA == '0) || (busyA == '1)), 32'h1);
        end
        check("all_down", 32'({clkA, busyA}), 32'h0);

        // Async reset while channel 3 sits in RST_REL
        enA[3] = 1'b1;
        steps(11);
        check("rstrel_rst_n", 32'(rstnA[3]), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("async_clk_en", 32'(clkA[3]), 32'h0);
        check("async_rst_n", 32'(rstnA[3]), 32'h0);
        check("async_isolate", 32'(isoA[3]), 32'h1);
        model_reset();
        #1 rst = 1'b0;
        steps(15);
        check("restart_not_on_yet", 32'(onA[3]), 32'h0);
        step();
        check("restart_on", 32'(onA[3]), 32'h1);
        enA = '0;
        steps(40);

        // IsolateClusters=0 instance: isolated_i is ignored
        enB[4] = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            isinB = NC'($urandom);
            step();
            check("B_isolate_zero", 32'({isoB, toB}), 32'h0);
            if (onB[4] && n == 0) n = i;
        end
        check("B_on_cycle", 32'(n), 32'd14);
        enB = '0;
        steps(20);

        // Randomized traffic on both instances
        fmA = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 39) == 0) enA[c] = ~enA[c];
                if ($urandom_range(0, 39) == 0) enB[c] = ~enB[c];
                clrA[c] = ($urandom_range(0, 49) == 0);
                clrB[c] = ($urandom_range(0, 49) == 0);
                isinB[c] = 1'($urandom_range(0, 1));
            end
            step();
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1) isinA[c] = isoA[c];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
